fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Fetch stage directly downstream of the program counter. Takes the PC value, issues a
//  1-cycle-latency instruction-memory read, and buffers {pc, instr} pairs in a small ring
//  queue. Presents them to decode over a valid/ready handshake. Backpressures the PC via
//  pc_ready. Supports a branch/redirect flush.
// PARAMETERS
//  ADDR_W   32  PC / instruction-memory address width
//  INSTR_W  32  instruction word width
//  DEPTH    4   queue entries; power of 2, >=2
// PORTS
//  clk         in   1        single clock, rising edge
//  reset       in   1        asynchronous, active-high reset
//  pc_in       in   ADDR_W   PC value from program counter
//  pc_valid    in   1        pc_in is valid this cycle
//  pc_ready    out  1        fetch accepts pc_in this cycle (PC must hold when low)
//  imem_req    out  1        instruction-memory read strobe
//  imem_addr   out  ADDR_W   instruction-memory read address
//  imem_rdata  in   INSTR_W  read data, valid exactly 1 cycle after imem_req
//  dec_valid   out  1        head entry is valid
//  dec_ready   in   1        decode consumes head this cycle
//  dec_instr   out  INSTR_W  head instruction
//  dec_pc      out  ADDR_W   PC of head instruction
//  flush       in   1        discard all buffered and in-flight fetches
// BEHAVIOUR
//  - Reset (async): queue empty, rd/wr ptrs 0, inflight 0; pc_ready=0 while reset is high,
//    imem_req=0, imem_addr=0, dec_valid=0, dec_instr=0, dec_pc=0.
//  - Occupancy: count (clog2(DEPTH+1) bits) + inflight (1 bit).
//    pc_ready = !flush && (count + inflight < DEPTH); counts at most DEPTH, never wraps.
//  - Issue: pc_valid && pc_ready -> imem_req=1, imem_addr=pc_in (combinational);
//    pc_in is registered as pend_pc and inflight is set.
//  - Response: cycle after issue, if inflight && !flush, {pend_pc, imem_rdata} is written
//    at wr_ptr; wr_ptr++ (mod DEPTH), count++.
//  - Pop: dec_valid = (count != 0). dec_valid && dec_ready -> rd_ptr++ (mod DEPTH), count--.
//    dec_instr/dec_pc show the head entry and stay stable while dec_valid && !dec_ready.
//  - Simultaneous write + pop: count unchanged, both pointers advance; a full queue with
//    a pop in the same cycle re-opens pc_ready on the next cycle.
//  - Back-to-back: one issue per cycle. Steady state is 1 instr/cycle when decode is ready.
//  - Empty bypass is not provided. Fetch-to-dec_valid latency is 2 cycles.
//  - flush (sync, 1 cycle): pointers and count go to 0 and inflight is cleared; a response
//    due that cycle is dropped. pc_ready=0 and no issue occur in the flush cycle.
//    dec_valid=0 from the next cycle on.
//  - When empty, dec_instr/dec_pc hold their last values (don't-care for decode).
//  - Reset mid-operation: all state clears immediately, and an in-flight response is ignored.
// CONFIGURATION
//  FETCHQ_STATS_EN defined:
//    adds out port stall_cycles[31:0], which counts cycles with pc_valid && !pc_ready.
//    Cleared by reset, not by flush; saturates at 32'hFFFF_FFFF.
//  FETCHQ_STATS_EN undefined: the port and counter do not exist; behaviour is otherwise identical.
// STRUCTURE
//  - Package fetchq_pkg: ADDR_W/INSTR_W defaults; typedef fetch_entry_t {pc, instr}.
//  - Sub-module fetchq_ring: DEPTH x fetch_entry_t storage with wr_en/wr_ptr and rd_ptr
//    read port.
//  - Top: pointers, count, inflight, handshake, flush, and the optional stats counter.
// TESTING
//  1. Reset then pc_valid=1, pc_in=0,1,2,3, dec_ready=1 -> imem_addr 0..3 on successive
//     cycles; dec_pc 0..3 with matching instrs, each 2 cycles after issue.
//  2. dec_ready=0, stream PCs -> 4 entries held; pc_ready=0 after 4 issues.
//     dec_ready=1 for one cycle -> pc_ready=1 the next cycle.
//  3. Full queue, dec_ready=1 and response write in the same cycle -> count stays 4 and
//     order is preserved across pointer wrap (PCs 0..9).
//  4. flush in the cycle a response for pc=5 returns -> pc=5 never appears on dec_pc,
//     and dec_valid=0 the next cycle; refetch from pc=20 yields dec_pc=20 first.
//  5. Assert reset while 3 entries are queued and one is in flight -> all outputs go to reset
//     values without a clock edge; after release, dec_valid=0 until a new fetch.
//  6. FETCHQ_STATS_EN: hold the queue full with pc_valid=1 for 10 cycles -> stall_cycles=10;
//     flush leaves it at 10.

Source files
------------

// File: rtl/fetchq_pkg.sv
// Shared definitions for the fetch queue: default widths/depth and the
// {pc, instr} entry layout used by decode-facing consumers.
package fetchq_pkg;

    localparam int FQ_ADDR_W  = 32;
    localparam int FQ_INSTR_W = 32;
    localparam int FQ_DEPTH   = 4;

    // One buffered fetch: the PC and the instruction word read from it.
    typedef struct packed {
        logic [FQ_ADDR_W-1:0]  pc;
        logic [FQ_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetchq_ring.sv
// Ring storage for the fetch queue: DEPTH entries, one write port addressed by
// wr_ptr and one asynchronous read port addressed by rd_ptr. Entries carry
// data only, so the array has no reset; validity is tracked by the owner.
module fetchq_ring #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 64,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_ptr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [PTR_W-1:0]   rd_ptr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Capture a returning fetch into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: issues 1-cycle-latency instruction-memory reads for accepted
// PCs and buffers {pc, instr} pairs for decode in a small ring.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. pc_ready does not depend on pc_valid; dec_valid does not depend
// on dec_ready. The PC source must hold pc_in while pc_ready is low.
//
// Optional feature: define FETCHQ_STATS_EN to add the stall_cycles output,
// a saturating count of cycles with pc_valid && !pc_ready.
module fetch_queue
    import fetchq_pkg::*;
#(
    parameter int ADDR_W  = FQ_ADDR_W,
    parameter int INSTR_W = FQ_INSTR_W,
    parameter int DEPTH   = FQ_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               flush
`ifdef FETCHQ_STATS_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               inflight;
    logic [ADDR_W-1:0]  pend_pc;
    logic [CNT_W:0]     occupancy;
    logic               issue;
    logic               wr_en;
    logic               pop;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] last_entry;

    // An in-flight read already owns a slot, so it counts toward occupancy.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign pc_ready  = !reset && !flush && (occupancy < (CNT_W + 1)'(DEPTH));
    assign issue     = pc_valid && pc_ready;
    assign imem_req  = issue;
    assign imem_addr = issue ? pc_in : '0;

    // A response arriving in a flush cycle belongs to the discarded path.
    assign wr_en     = inflight && !flush;
    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready;

    fetchq_ring #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ring (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_ptr  (wr_ptr),
        .wr_data ({pend_pc, imem_rdata}),
        .rd_ptr  (rd_ptr),
        .rd_data (head_entry)
    );

    // Pointer, count and in-flight bookkeeping; flush wipes the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            pend_pc  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pend_pc <= pc_in;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Remember the last head shown so decode-facing outputs hold when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_entry <= '0;
        end else if (dec_valid) begin
            last_entry <= head_entry;
        end
    end

    assign {dec_pc, dec_instr} = dec_valid ? head_entry : last_entry;

`ifdef FETCHQ_STATS_EN
    // Count PC stall cycles; survives flush and saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (pc_valid && !pc_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based reference model of the fetch stage.
`timescale 1ns/1ps
module tb_fetch_queue;
    import fetchq_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        flush = 1'b0;
`ifdef FETCHQ_STATS_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_instr  (dec_instr),
        .dec_pc     (dec_pc),
        .flush      (flush)
`ifdef FETCHQ_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    // Memory returns data one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;
    end

    // ---------------- reference model + scoreboard ----------------
    fetch_entry_t exp_q[$];
    logic         m_inflight = 1'b0;
    logic [31:0]  m_pend_pc = '0;
    fetch_entry_t m_last = '0;
    logic [31:0]  m_stall = '0;
    logic [31:0]  cur_pc = '0;
    int           n_tests = 0;
    int           n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: drive inputs, compare outputs to the model, then advance it.
    task automatic step(input logic pv, input logic [31:0] pc, input logic dr,
                        input logic fl, output logic accepted);
        logic         e_ready;
        logic         e_issue;
        logic         e_valid;
        fetch_entry_t e_head;
        @(negedge clk);
        pc_valid  = pv;
        pc_in     = pc;
        dec_ready = dr;
        flush     = fl;
        #1;
        e_ready = !fl && ((exp_q.size() + int'(m_inflight)) < DEPTH);
        e_issue = pv && e_ready;
        e_valid = (exp_q.size() != 0);
        if (e_valid) e_head = exp_q[0];
        else         e_head = m_last;
        check("pc_ready",  {63'd0, pc_ready},  {63'd0, e_ready});
        check("imem_req",  {63'd0, imem_req},  {63'd0, e_issue});
        check("imem_addr", {32'd0, imem_addr}, {32'd0, (e_issue ? pc : 32'd0)});
        check("dec_valid", {63'd0, dec_valid}, {63'd0, e_valid});
        check("dec_pc",    {32'd0, dec_pc},    {32'd0, e_head.pc});
        check("dec_instr", {32'd0, dec_instr}, {32'd0, e_head.instr});
`ifdef FETCHQ_STATS_EN
        check("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stall});
`endif
        @(posedge clk);
        if (pv && !e_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
        if (e_valid) m_last = exp_q[0];
        if (fl) begin
            exp_q.delete();
            m_inflight = 1'b0;
        end else begin
            if (e_valid && dr) void'(exp_q.pop_front());
            if (m_inflight) exp_q.push_back({m_pend_pc, mem_word(m_pend_pc)});
            m_inflight = e_issue;
            if (e_issue) m_pend_pc = pc;
        end
        accepted = e_issue;
    endtask

    // Offer cur_pc; move to the next sequential PC once it is taken.
    task automatic feed(input logic pv, input logic dr, input logic fl);
        logic acc;
        step(pv, cur_pc, dr, fl, acc);
        if (acc) cur_pc = cur_pc + 32'd1;
    endtask

    task automatic idle(input int n, input logic dr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, cur_pc, dr, 1'b0, acc);
    endtask

    // Assert reset between edges and check outputs clear with no clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset     = 1'b1;
        pc_valid  = 1'b1;
        pc_in     = 32'h55;
        dec_ready = 1'b0;
        flush     = 1'b0;
        #1;
        check("rst_pc_ready",  {63'd0, pc_ready},  64'd0);
        check("rst_imem_req",  {63'd0, imem_req},  64'd0);
        check("rst_imem_addr", {32'd0, imem_addr}, 64'd0);
        check("rst_dec_valid", {63'd0, dec_valid}, 64'd0);
        check("rst_dec_pc",    {32'd0, dec_pc},    64'd0);
        check("rst_dec_instr", {32'd0, dec_instr}, 64'd0);
`ifdef FETCHQ_STATS_EN
        check("rst_stall", {32'd0, stall_cycles}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        pc_valid = 1'b0;
        exp_q.delete();
        m_inflight = 1'b0;
        m_pend_pc  = '0;
        m_last     = '0;
        m_stall    = '0;
        cur_pc     = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;

        // 1: sequential stream with decode ready; 2-cycle latency.
        do_reset();
        for (int i = 0; i < 2; i++) feed(1'b1, 1'b1, 1'b0);
        #1;
        check("t1_lat_valid", {63'd0, dec_valid}, 64'd1);
        check("t1_lat_pc",    {32'd0, dec_pc},    64'd0);
        for (int i = 0; i < 2; i++) feed(1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);

        // 2: decode stalled fills the queue; one pop re-opens pc_ready.
        do_reset();
        for (int i = 0; i < 5; i++) feed(1'b1, 1'b0, 1'b0);
        #1;
        check("t2_full_ready", {63'd0, pc_ready}, 64'd0);
        feed(1'b1, 1'b1, 1'b0);
        #1;
        check("t2_reopen_ready", {63'd0, pc_ready}, 64'd1);
        idle(6, 1'b1);

        // 3: full queue then pop+write overlap across pointer wrap, PCs 0..9.
        do_reset();
        for (int i = 0; i < 6; i++) feed(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (cur_pc != 32'd10 && guard < 40) begin
            feed(1'b1, 1'b1, 1'b0);
            guard++;
        end
        check("t3_stream_done", {32'd0, cur_pc}, 64'd10);
        idle(6, 1'b1);
        #1;
        check("t3_drained", {63'd0, dec_valid}, 64'd0);

        // 4: flush exactly when pc=5 returns; then redirect to 20.
        do_reset();
        guard = 0;
        while (cur_pc != 32'd6 && guard < 20) begin
            feed(1'b1, 1'b1, 1'b0);
            guard++;
        end
        feed(1'b0, 1'b1, 1'b1);
        #1;
        check("t4_flush_valid", {63'd0, dec_valid}, 64'd0);
        cur_pc = 32'd20;
        feed(1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        #1;
        check("t4_refetch_valid", {63'd0, dec_valid}, 64'd1);
        check("t4_refetch_pc",    {32'd0, dec_pc},    64'd20);
        idle(3, 1'b1);

        // 5: reset with three queued and one in flight.
        do_reset();
        cur_pc = 32'd100;
        for (int i = 0; i < 4; i++) feed(1'b1, 1'b0, 1'b0);
        do_reset();
        idle(3, 1'b1);
        #1;
        check("t5_post_reset_valid", {63'd0, dec_valid}, 64'd0);

        // 6: hold full with pc_valid for 10 cycles, then flush.
        do_reset();
        for (int i = 0; i < 4; i++) feed(1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 10; i++) feed(1'b1, 1'b0, 1'b0);
`ifdef FETCHQ_STATS_EN
        #1;
        check("t6_stall_10", {32'd0, stall_cycles}, 64'd10);
`endif
        feed(1'b0, 1'b0, 1'b1);
`ifdef FETCHQ_STATS_EN
        #1;
        check("t6_stall_after_flush", {32'd0, stall_cycles}, 64'd10);
`endif
        idle(2, 1'b1);

        // Randomized traffic with occasional flush/redirect and one reset.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic pv;
            logic dr;
            logic fl;
            pv = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 31) == 0);
            feed(pv, dr, fl);
            if (fl) cur_pc = $urandom;
            if (i == 1000) do_reset();
        end
        idle(6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
